// File: rtl/risc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency instruction memory,
// and loads the IF/ID register while honouring stall (hazard) and redirect (branch).
module risc_fetch_stage #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP_INST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              inst_ld
);

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] fetched_pc, fetched_pc_nx;
  logic [ADDR_W-1:0] skid_pc, skid_pc_nx;
  logic [INST_W-1:0] skid_inst, skid_inst_nx;
  logic [INST_W-1:0] if_id_inst_nx;
  logic [ADDR_W-1:0] if_id_pc_nx;
  logic              if_id_valid_nx;
  logic              inst_ld_nx;

  assign imem_addr = pc;

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
    state_nx       = state;
    pc_nx          = pc;
    fetched_pc_nx  = fetched_pc;
    skid_pc_nx     = skid_pc;
    skid_inst_nx   = skid_inst;
    if_id_inst_nx  = if_id_inst;
    if_id_pc_nx    = if_id_pc;
    if_id_valid_nx = if_id_valid;
    inst_ld_nx     = 1'b0;

    if (branch_taken) begin
      // Redirect discards in-flight and skid data; the pipe refills from the target.
      pc_nx          = branch_target;
      skid_pc_nx     = '0;
      skid_inst_nx   = NOP_INST;
      if_id_inst_nx  = NOP_INST;
      if_id_valid_nx = 1'b0;
      state_nx       = FILL;
    end else begin
      unique case (state)
        FILL: begin
          fetched_pc_nx  = pc;
          pc_nx          = pc + ADDR_W'(1);
          if_id_inst_nx  = NOP_INST;
          if_id_valid_nx = 1'b0;
          state_nx       = RUN;
        end
        RUN: begin
          if (!stall) begin
            if_id_inst_nx  = imem_rdata;
            if_id_pc_nx    = fetched_pc;
            if_id_valid_nx = 1'b1;
            inst_ld_nx     = 1'b1;
            fetched_pc_nx  = pc;
            pc_nx          = pc + ADDR_W'(1);
          end else begin
            // The returning word would be lost while pc re-reads, so park it.
            skid_inst_nx = imem_rdata;
            skid_pc_nx   = fetched_pc;
            state_nx     = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_inst_nx  = skid_inst;
            if_id_pc_nx    = skid_pc;
            if_id_valid_nx = 1'b1;
            inst_ld_nx     = 1'b1;
            fetched_pc_nx  = pc;
            pc_nx          = pc + ADDR_W'(1);
            state_nx       = RUN;
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= FILL;
      pc          <= RESET_PC;
      fetched_pc  <= '0;
      skid_pc     <= '0;
      skid_inst   <= NOP_INST;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      inst_ld     <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      fetched_pc  <= fetched_pc_nx;
      skid_pc     <= skid_pc_nx;
      skid_inst   <= skid_inst_nx;
      if_id_inst  <= if_id_inst_nx;
      if_id_pc    <= if_id_pc_nx;
      if_id_valid <= if_id_valid_nx;
      inst_ld     <= inst_ld_nx;
    end
  end

endmodule

// File: tb/tb_risc_fetch_stage.sv
// Self-checking bench for risc_fetch_stage: directed scenarios plus a randomized run
// checked against a transaction-level model of the IF/ID instruction stream.
module tb_risc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] if_id_inst;
  logic [7:0]  if_id_pc;
  logic        if_id_valid, inst_ld;

  // Second instance exercises PC wrap from RESET_PC = FE.
  logic        rst_w;
  logic        zero_w = 1'b0;
  logic [7:0]  tgt_w = 8'h00;
  logic [7:0]  addr_w;
  logic [15:0] rdata_w;
  logic [15:0] inst_w;
  logic [7:0]  pc_w;
  logic        valid_w, ld_w;

  int n_cmp = 0;
  int n_err = 0;

  // Model: what the IF/ID register should show, plus the next address owed to decode.
  logic        m_valid, m_ld, m_fill;
  logic [7:0]  m_pc, m_next;
  logic [15:0] m_inst;

  wire [25:0] obs   = {if_id_valid, inst_ld, if_id_pc, if_id_inst};
  wire [25:0] obs_w = {valid_w, ld_w, pc_w, inst_w};

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 16'h1000 + 16'(imem_addr);
  always @(posedge clk) rdata_w    <= 16'h1000 + 16'(addr_w);

  risc_fetch_stage #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'h00), .NOP_INST(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .inst_ld(inst_ld)
  );

  risc_fetch_stage #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'hFE), .NOP_INST(16'h0000)) dut_w (
    .clk(clk), .reset(rst_w), .stall(zero_w), .branch_taken(zero_w),
    .branch_target(tgt_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
    .if_id_inst(inst_w), .if_id_pc(pc_w), .if_id_valid(valid_w), .inst_ld(ld_w)
  );

  function automatic logic [25:0] exp_obs(input logic v, input logic l, input logic [7:0] p);
    return {v, l, p, (v ? 16'h1000 + 16'(p) : 16'h0000)};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic tick(input logic r, input logic s, input logic b, input logic [7:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    m_ld = 1'b0;
    if (r) begin
      m_valid = 1'b0; m_pc = 8'h00; m_inst = 16'h0000; m_next = 8'h00; m_fill = 1'b1;
    end else if (b) begin
      m_valid = 1'b0; m_inst = 16'h0000; m_next = t; m_fill = 1'b1;
    end else if (m_fill) begin
      m_valid = 1'b0; m_inst = 16'h0000; m_fill = 1'b0;
    end else if (!s) begin
      m_valid = 1'b1; m_ld = 1'b1; m_pc = m_next; m_inst = 16'h1000 + 16'(m_next);
      m_next = m_next + 8'h01;
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs !== 26'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 26'h0);
    end
    n_cmp++;
    if (imem_addr !== 8'h00) begin
      n_err++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs !== exp_obs(1'b0, 1'b0, 8'h00)) begin
      n_err++; $display("FAIL reset_first_edge: got %h want %h", obs, exp_obs(1'b0, 1'b0, 8'h00));
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b1, 8'(i))) begin
        n_err++; $display("FAIL reset_stream[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b1, 8'(i)));
      end
    end
  endtask

  task automatic test_stall;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs !== exp_obs(1'b1, 1'b1, 8'h05)) begin
      n_err++; $display("FAIL stall_setup: got %h want %h", obs, exp_obs(1'b1, 1'b1, 8'h05));
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b0, 8'h05)) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b0, 8'h05));
      end
    end
    for (int i = 6; i <= 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b1, 8'(i))) begin
        n_err++; $display("FAIL stall_resume[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b1, 8'(i)));
      end
    end
  endtask

  task automatic test_branch;
    logic [25:0] bub;
    tick(1'b0, 1'b0, 1'b1, 8'h40);
    bub = {2'b00, if_id_pc, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (if_id_valid !== 1'b0 || inst_ld !== 1'b0 || if_id_inst !== 16'h0000) begin
        n_err++; $display("FAIL branch_bubble[%0d]: got %h want valid=0 ld=0 inst=0000", i, obs);
      end
      if (i == 0) tick(1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b1, 8'h40 + 8'(i))) begin
        n_err++; $display("FAIL branch_target[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b1, 8'h40 + 8'(i)));
      end
    end
    if (bub[25] !== 1'b0) $display("note: unexpected bubble sample %h", bub);
  endtask

  task automatic test_branch_over_stall;
    tick(1'b0, 1'b1, 1'b1, 8'h20);
    n_cmp++;
    if (if_id_valid !== 1'b0 || inst_ld !== 1'b0) begin
      n_err++; $display("FAIL branch_stall_edge: got valid=%b ld=%b want 0 0", if_id_valid, inst_ld);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (if_id_valid !== 1'b0 || inst_ld !== 1'b0) begin
      n_err++; $display("FAIL branch_stall_held: got valid=%b ld=%b want 0 0", if_id_valid, inst_ld);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b1, 8'h20 + 8'(i))) begin
        n_err++; $display("FAIL branch_stall_target[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b1, 8'h20 + 8'(i)));
      end
    end
  endtask

  task automatic test_reset_in_hold;
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (obs !== 26'h0 || imem_addr !== 8'h00) begin
      n_err++; $display("FAIL reset_in_hold: got %h addr=%h want %h addr=00", obs, imem_addr, 26'h0);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_obs(1'b1, 1'b1, 8'(i))) begin
        n_err++; $display("FAIL reset_in_hold_restart[%0d]: got %h want %h", i, obs, exp_obs(1'b1, 1'b1, 8'(i)));
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] seq [4];
    seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
    rst_w = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs_w !== 26'h0 || addr_w !== 8'hFE) begin
      n_err++; $display("FAIL wrap_reset: got %h addr=%h want %h addr=fe", obs_w, addr_w, 26'h0);
    end
    rst_w = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs_w !== exp_obs(1'b1, 1'b1, seq[i])) begin
        n_err++; $display("FAIL wrap_seq[%0d]: got %h want %h", i, obs_w, exp_obs(1'b1, 1'b1, seq[i]));
      end
    end
  endtask

  task automatic test_random;
    logic r, s, b;
    logic [7:0] t;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = 8'($urandom);
      tick(r, s, b, t);
      n_cmp++;
      if (obs !== {m_valid, m_ld, m_pc, m_inst}) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, {m_valid, m_ld, m_pc, m_inst});
      end
      n_cmp++;
      if (inst_ld === 1'b1 && if_id_valid !== 1'b1) begin
        n_err++; $display("FAIL random_ld_valid[%0d]: got ld=1 valid=%b want valid=1", i, if_id_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; rst_w = 1'b1;
    m_valid = 1'b0; m_ld = 1'b0; m_fill = 1'b1; m_pc = 8'h00; m_next = 8'h00; m_inst = 16'h0000;
    test_reset;
    test_stall;
    test_branch;
    test_branch_over_stall;
    test_reset_in_hold;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
